// File: rtl/alu_pkg.sv
// Shared ALU/arbiter types: opcodes, flag bit positions and arbiter FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_INC  = 3'd5,
        OP_MOVA = 3'd6,
        OP_MOVB = 3'd7
    } alu_op_t;

    // Flag vector is read MSB-first as zero, negative, overflow.
    localparam int FLAG_OVF  = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_ZERO = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational BW-bit two's-complement ALU with zero/negative/overflow flags.
module alu
    import alu_pkg::*;
#(
    parameter int BW = 16
) (
    input  logic signed [BW-1:0] a,
    input  logic signed [BW-1:0] b,
    input  alu_op_t              op,
    output logic signed [BW-1:0] y,
    output logic [2:0]           flags
);

    logic ovf;

    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                y   = a + b;
                ovf = (a[BW-1] == b[BW-1]) && (y[BW-1] != a[BW-1]);
            end
            OP_SUB: begin
                y   = a - b;
                ovf = (a[BW-1] != b[BW-1]) && (y[BW-1] != a[BW-1]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_INC:  y = a + BW'(1);
            OP_MOVA: y = a;
            OP_MOVB: y = b;
            default: y = '0;
        endcase
    end

    always_comb begin
        flags            = '0;
        flags[FLAG_OVF]  = ovf;
        flags[FLAG_NEG]  = y[BW-1];
        flags[FLAG_ZERO] = (y == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared ALU with a valid/ready response.
// Optional ALU_ARBITER_OVF_CNT_EN adds a saturating 8-bit overflow event counter.
//
// state   | meaning
// IDLE    | grant one valid requester, capture its operands
// EXEC    | evaluate ALU on captured operands, register result
// RESP    | hold result valid until the consumer accepts it
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int BW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][BW-1:0]    req_a,
    input  logic [1:0][BW-1:0]    req_b,
    input  logic [1:0][2:0]       req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic signed [BW-1:0]  rsp_out,
    output logic [2:0]            rsp_flags
`ifdef ALU_ARBITER_OVF_CNT_EN
    ,
    output logic [7:0]            ovf_cnt
`endif
);

    state_t             state;
    logic               last_id;
    logic               op_id;
    logic signed [BW-1:0] op_a;
    logic signed [BW-1:0] op_b;
    alu_op_t            op_code;
    logic [1:0]         grant;
    logic               gid;
    logic signed [BW-1:0] alu_y;
    logic [2:0]         alu_flags;

    // Under contention the requester that was not served last wins.
    always_comb begin
        grant = 2'b00;
        if (state == ST_IDLE && !rst) begin
            if (req_valid == 2'b11)
                grant = last_id ? 2'b01 : 2'b10;
            else
                grant = req_valid;
        end
    end

    assign gid       = grant[1];
    assign req_ready = grant;

    alu #(.BW(BW)) u_alu (
        .a     (op_a),
        .b     (op_b),
        .op    (op_code),
        .y     (alu_y),
        .flags (alu_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            last_id   <= 1'b1;
            op_id     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_code   <= OP_ADD;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_out   <= '0;
            rsp_flags <= '0;
`ifdef ALU_ARBITER_OVF_CNT_EN
            ovf_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        op_id   <= gid;
                        op_a    <= req_a[gid];
                        op_b    <= req_b[gid];
                        op_code <= alu_op_t'(req_op[gid]);
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_out   <= alu_y;
                    rsp_flags <= alu_flags;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    last_id   <= op_id;
                    state     <= ST_RESP;
`ifdef ALU_ARBITER_OVF_CNT_EN
                    if (alu_flags[FLAG_OVF] && ovf_cnt != 8'hFF)
                        ovf_cnt <= ovf_cnt + 8'd1;
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
